// File: rtl/card_pkg.sv
// Shared types and helpers for the card dealer and the game-rule FSM that reads its hands.
package card_pkg;

    localparam int CARD_W_DEFAULT = 6;
    localparam int MAX_PLAYERS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BURN = 2'd1,
        ST_DEAL = 2'd2,
        ST_DONE = 2'd3
    } deal_state_t;

    // Bit offset of seat p, slot k inside the flattened hands vector.
    function automatic int seat_slot_lsb(input int p, input int k,
                                         input int cards_per_hand, input int card_w);
        return (p * cards_per_hand + k) * card_w;
    endfunction

endpackage

// File: rtl/rr_seat_counter.sv
// Round-robin seat/slot counter: seat advances per card, slot advances when the seat wraps.
module rr_seat_counter #(
    parameter int NUM_PLAYERS    = 2,
    parameter int CARDS_PER_HAND = 2,
    parameter int PW             = 1,
    parameter int SW             = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [PW-1:0] cur_player,
    output logic [SW-1:0] slot,
    output logic          last_seat,
    output logic          last_slot
);

    logic [PW-1:0] r_player;
    logic [SW-1:0] r_slot;

    assign last_seat  = (r_player == PW'(NUM_PLAYERS - 1));
    assign last_slot  = (r_slot == SW'(CARDS_PER_HAND - 1));
    assign cur_player = r_player;
    assign slot       = r_slot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_player <= '0;
            r_slot   <= '0;
        end else if (clear) begin
            r_player <= '0;
            r_slot   <= '0;
        end else if (advance) begin
            if (last_seat) begin
                r_player <= '0;
                r_slot   <= last_slot ? '0 : r_slot + 1'b1;
            end else begin
                r_player <= r_player + 1'b1;
            end
        end
    end

endmodule

// File: rtl/card_deal_ctrl.sv
// Deals a valid/ready card stream round-robin into per-seat hands; flags each completed hand.
// CARD_DEAL_BURN_EN: discard the first card after start (BURN state) before dealing.
module card_deal_ctrl
    import card_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int CARDS_PER_HAND = 2,
    parameter int CARD_W         = CARD_W_DEFAULT,
    localparam int PW            = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int HW            = NUM_PLAYERS * CARDS_PER_HAND * CARD_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   card_valid,
    input  logic [CARD_W-1:0]      card_in,
    output logic                   card_ready,
    output logic [HW-1:0]          hands,
    output logic [NUM_PLAYERS-1:0] handed,
    output logic [PW-1:0]          cur_player,
    output logic                   busy,
    output logic                   deal_done
);

    localparam int SW = (CARDS_PER_HAND > 1) ? $clog2(CARDS_PER_HAND) : 1;
`ifdef CARD_DEAL_BURN_EN
    localparam deal_state_t START_STATE = ST_BURN;
`else
    localparam deal_state_t START_STATE = ST_DEAL;
`endif

    deal_state_t             r_state, w_next;
    logic [HW-1:0]           r_hands;
    logic [NUM_PLAYERS-1:0]  r_handed;
    logic                    r_deal_done;
    logic                    w_clear, w_busy, w_xfer, w_advance;
    logic [PW-1:0]           w_cur_player;
    logic [SW-1:0]           w_slot;
    logic                    w_last_seat, w_last_slot;

    assign w_busy    = (r_state == ST_BURN) || (r_state == ST_DEAL);
    assign w_xfer    = card_valid && w_busy;
    assign w_advance = w_xfer && (r_state == ST_DEAL) && !abort;

    rr_seat_counter #(
        .NUM_PLAYERS    (NUM_PLAYERS),
        .CARDS_PER_HAND (CARDS_PER_HAND),
        .PW             (PW),
        .SW             (SW)
    ) u_seat_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .advance    (w_advance),
        .cur_player (w_cur_player),
        .slot       (w_slot),
        .last_seat  (w_last_seat),
        .last_slot  (w_last_slot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // abort outranks start and any transfer, including the final one.
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        if (abort) begin
            w_next  = ST_IDLE;
            w_clear = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (start) begin
                    w_next  = START_STATE;
                    w_clear = 1'b1;
                end
                ST_BURN: if (w_xfer) w_next = ST_DEAL;
                ST_DEAL: if (w_xfer && w_last_seat && w_last_slot) w_next = ST_DONE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hands     <= '0;
            r_handed    <= '0;
            r_deal_done <= 1'b0;
        end else begin
            r_deal_done <= w_advance && w_last_seat && w_last_slot;
            if (w_clear) begin
                r_hands  <= '0;
                r_handed <= '0;
            end else if (w_advance) begin
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (int'(w_cur_player) == p) begin
                        if (w_last_slot) r_handed[p] <= 1'b1;
                        for (int k = 0; k < CARDS_PER_HAND; k++) begin
                            if (int'(w_slot) == k)
                                r_hands[seat_slot_lsb(p, k, CARDS_PER_HAND, CARD_W) +: CARD_W] <= card_in;
                        end
                    end
                end
            end
        end
    end

    assign card_ready = w_busy;
    assign busy       = w_busy;
    assign hands      = r_hands;
    assign handed     = r_handed;
    assign cur_player = w_cur_player;
    assign deal_done  = r_deal_done;

endmodule

// File: tb/tb_card_deal_ctrl.sv
module tb_card_deal_ctrl;

    localparam int NP = 2, CPH = 2, CW = 6, TOT = NP * CPH;
    localparam int NP3 = 3, CPH3 = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start, abort, valid;
    logic [5:0]  card;
    logic        card_ready, busy, deal_done;
    logic [23:0] hands;
    logic [1:0]  handed;
    logic [0:0]  curp;

    logic        start3, abort3, valid3;
    logic [5:0]  card3;
    logic        ready3, busy3, done3;
    logic [17:0] hands3;
    logic [2:0]  handed3;
    logic [1:0]  curp3;

    int n_checks = 0;
    int n_errors = 0;

    card_deal_ctrl #(.NUM_PLAYERS(NP), .CARDS_PER_HAND(CPH), .CARD_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .card_valid(valid), .card_in(card), .card_ready(card_ready),
        .hands(hands), .handed(handed), .cur_player(curp),
        .busy(busy), .deal_done(deal_done)
    );

    card_deal_ctrl #(.NUM_PLAYERS(NP3), .CARDS_PER_HAND(CPH3), .CARD_W(CW)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort3),
        .card_valid(valid3), .card_in(card3), .card_ready(ready3),
        .hands(hands3), .handed(handed3), .cur_player(curp3),
        .busy(busy3), .deal_done(done3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burn_a();
`ifdef CARD_DEAL_BURN_EN
        valid = 1'b1; card = 6'h3F;
        tick();
        valid = 1'b0;
        n_checks++;
        if (hands !== 24'h0 || curp !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL burn: hands=%h curp=%0d busy=%b, want 0/0/1", hands, curp, busy);
        end
`endif
    endtask

    task automatic burn_3();
`ifdef CARD_DEAL_BURN_EN
        valid3 = 1'b1; card3 = 6'h3F;
        tick();
        valid3 = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; abort = 0; valid = 0; card = 0;
        start3 = 0; abort3 = 0; valid3 = 0; card3 = 0;
        #3;
        n_checks++;
        if ({busy, card_ready, deal_done, handed, curp} !== 6'b0 || hands !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_a: busy=%b rdy=%b done=%b handed=%b curp=%0d hands=%h, want all 0",
                     busy, card_ready, deal_done, handed, curp, hands);
        end
        n_checks++;
        if ({busy3, ready3, done3, handed3, curp3} !== 8'b0 || hands3 !== 18'h0) begin
            n_errors++;
            $display("FAIL reset_3: busy=%b handed=%b curp=%0d hands=%h, want all 0",
                     busy3, handed3, curp3, hands3);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Deals one full hand set on dut and checks every step against a seat/slot arithmetic model.
    task automatic deal_a(input bit gaps, input bit fixed, output logic [23:0] exp_h);
        logic [23:0] exp;
        logic [1:0]  exp_handed;
        logic [5:0]  c;
        int          cnt[NP];
        int          seat, slot;
        exp = '0; exp_handed = '0;
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || hands !== 24'h0 || handed !== 2'b00 || curp !== 1'b0) begin
            n_errors++;
            $display("FAIL start: busy=%b hands=%h handed=%b curp=%0d, want 1/0/00/0", busy, hands, handed, curp);
        end
        burn_a();
        for (int i = 0; i < TOT; i++) begin
            if (gaps) begin
                repeat ($urandom_range(1, 2)) begin
                    valid = 1'b0; card = 6'($urandom);
                    tick();
                    n_checks++;
                    if (int'(curp) !== i % NP || handed !== exp_handed || hands !== exp) begin
                        n_errors++;
                        $display("FAIL gap_hold: curp=%0d handed=%b hands=%h, want %0d/%b/%h",
                                 curp, handed, hands, i % NP, exp_handed, exp);
                    end
                end
            end
            c = fixed ? 6'(i + 1) : 6'($urandom);
            valid = 1'b1; card = c;
            n_checks++;
            if (card_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL ready: card_ready=%b want 1 before card %0d", card_ready, i);
            end
            tick();
            seat = i % NP; slot = i / NP;
            exp[(seat * CPH + slot) * CW +: CW] = c;
            cnt[seat]++;
            if (cnt[seat] == CPH) exp_handed[seat] = 1'b1;
            n_checks++;
            if (handed !== exp_handed || int'(curp) !== (i + 1) % NP ||
                deal_done !== (i == TOT - 1) || busy !== (i != TOT - 1)) begin
                n_errors++;
                $display("FAIL step%0d: handed=%b curp=%0d done=%b busy=%b, want %b/%0d/%b/%b",
                         i, handed, curp, deal_done, busy, exp_handed, (i + 1) % NP,
                         i == TOT - 1, i != TOT - 1);
            end
        end
        card = 6'h2A;
        n_checks++;
        if (hands !== exp || card_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL hands: got %h rdy=%b, want %h rdy=0", hands, card_ready, exp);
        end
        tick();
        valid = 1'b0;
        n_checks++;
        if (deal_done !== 1'b0 || hands !== exp || handed !== 2'b11) begin
            n_errors++;
            $display("FAIL done_hold: done=%b hands=%h handed=%b, want 0/%h/11", deal_done, hands, handed, exp);
        end
        exp_h = exp;
    endtask

    task automatic test_basic();
        logic [23:0] h;
        deal_a(1'b0, 1'b1, h);
        n_checks++;
        if (hands !== {6'h04, 6'h02, 6'h03, 6'h01}) begin
            n_errors++;
            $display("FAIL basic_layout: hands=%h want %h", hands, {6'h04, 6'h02, 6'h03, 6'h01});
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] h;
        deal_a(1'b1, 1'b1, h);
        n_checks++;
        if (hands !== {6'h04, 6'h02, 6'h03, 6'h01}) begin
            n_errors++;
            $display("FAIL bp_layout: hands=%h want %h", hands, {6'h04, 6'h02, 6'h03, 6'h01});
        end
    endtask

    task automatic test_random();
        logic [23:0] h;
        repeat (4) deal_a(1'($urandom), 1'b0, h);
    endtask

    task automatic test_abort();
        logic [23:0] h;
        start = 1'b1; tick(); start = 1'b0;
        burn_a();
        repeat (2) begin valid = 1'b1; card = 6'($urandom); tick(); end
        abort = 1'b1; card = 6'h15;
        tick();
        abort = 1'b0; valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || hands !== 24'h0 || handed !== 2'b00 || deal_done !== 1'b0 || curp !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_mid: busy=%b hands=%h handed=%b done=%b curp=%0d, want all 0",
                     busy, hands, handed, deal_done, curp);
        end
        deal_a(1'b0, 1'b1, h);
        n_checks++;
        if (hands !== {6'h04, 6'h02, 6'h03, 6'h01}) begin
            n_errors++;
            $display("FAIL abort_redeal: hands=%h want %h", hands, {6'h04, 6'h02, 6'h03, 6'h01});
        end
        // Abort coinciding with the final transfer.
        start = 1'b1; tick(); start = 1'b0;
        burn_a();
        repeat (TOT - 1) begin valid = 1'b1; card = 6'($urandom); tick(); end
        valid = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; valid = 1'b0;
        n_checks++;
        if (deal_done !== 1'b0 || busy !== 1'b0 || hands !== 24'h0 || handed !== 2'b00) begin
            n_errors++;
            $display("FAIL abort_final: done=%b busy=%b hands=%h handed=%b, want 0/0/0/00",
                     deal_done, busy, hands, handed);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_vs_start: busy=%b want 0", busy);
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1; tick(); start = 1'b0;
        burn_a();
        repeat (TOT - 1) begin valid = 1'b1; card = 6'($urandom); tick(); end
        valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, card_ready, deal_done, handed, curp} !== 6'b0 || hands !== 24'h0) begin
            n_errors++;
            $display("FAIL async_reset: busy=%b rdy=%b done=%b handed=%b curp=%0d hands=%h, want all 0",
                     busy, card_ready, deal_done, handed, curp, hands);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_three_seats();
        logic [17:0] exp;
        logic [2:0]  exp_handed;
        logic [5:0]  c;
        exp = '0; exp_handed = '0;
        start3 = 1'b1; tick(); start3 = 1'b0;
        burn_3();
        for (int i = 0; i < NP3 * CPH3; i++) begin
            c = 6'($urandom);
            valid3 = 1'b1; card3 = c;
            start3 = (i == 1);
            n_checks++;
            if (int'(curp3) !== i % NP3) begin
                n_errors++;
                $display("FAIL seat3_cur: curp=%0d want %0d", curp3, i % NP3);
            end
            tick();
            start3 = 1'b0;
            exp[((i % NP3) * CPH3 + i / NP3) * CW +: CW] = c;
            exp_handed[i % NP3] = 1'b1;
            n_checks++;
            if (handed3 !== exp_handed || int'(curp3) !== (i + 1) % NP3 || done3 !== (i == NP3 * CPH3 - 1)) begin
                n_errors++;
                $display("FAIL seat3_step%0d: handed=%b curp=%0d done=%b, want %b/%0d/%b",
                         i, handed3, curp3, done3, exp_handed, (i + 1) % NP3, i == NP3 * CPH3 - 1);
            end
        end
        valid3 = 1'b0;
        n_checks++;
        if (hands3 !== exp || busy3 !== 1'b0) begin
            n_errors++;
            $display("FAIL seat3_hands: hands=%h busy=%b, want %h/0", hands3, busy3, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_abort();
        test_async_reset();
        test_three_seats();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
